// File: rtl/x_mod_m_seq.sv
// Sequential X mod M: Horner evaluation over K-bit chunks of X, MSB-first,
// one exact modular reduction per cycle. IDLE -> BUSY (N edges) -> DONE.
module x_mod_m_seq #(
  parameter  int XW = 300,
  parameter  int M  = 53,
  parameter  int K  = 6,
  localparam int RW = $clog2(M),
  localparam int N  = (XW + K - 1) / K,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] X,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] R,
  output logic          busy
);

  localparam int          NK = N * K;
  localparam int          PW = RW + K;
  localparam logic [RW:0] MV = (RW + 1)'(M);

  if (XW < 1 || M < 2 || M > 65535 || K < 1 || K > 16) begin : g_param_err
    $error("x_mod_m_seq: illegal parameters (need XW>=1, 2<=M<=65535, 1<=K<=16)");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [NK-1:0]   x_q;
  logic [RW-1:0]   r_q;
  logic [CW-1:0]   cnt_q;
  logic [K-1:0]    chunk;
  logic [PW-1:0]   pre;
  logic [RW-1:0]   r_next;

  // Exact reduction of v < M*2^K: restoring shift/subtract, one bit per step.
  // The running remainder stays below M, so 2t+bit < 2M needs one compare.
  function automatic logic [RW-1:0] mod_reduce(input logic [PW-1:0] v);
    logic [RW:0] t;
    t = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      t = {t[RW-1:0], v[i]};
      if (t >= MV) t = t - MV;
    end
    return t[RW-1:0];
  endfunction

  // Counter value n selects chunk n-1, so chunks come out MSB-first.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i + 1)) chunk = x_q[i*K +: K];
    end
  end

  assign pre    = {r_q, chunk};
  assign r_next = mod_reduce(pre);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_q   <= '0;
      cnt_q <= '0;
      x_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= NK'(X);
            r_q   <= '0;
            cnt_q <= CW'(N);
            state <= BUSY;
          end
        end
        BUSY: begin
          r_q   <= r_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign R         = r_q;

endmodule

// File: tb/tb_x_mod_m_seq.sv
// Bench for x_mod_m_seq: directed corner cases on the default build plus
// randomized operands on three parameter sets, checked against X % M.
module tb_x_mod_m_seq;

  localparam int XA = 300, MA = 53, KA = 6, NA = 50, RWA = 6;
  localparam int XB = 64,  MB = 7,  KB = 3, NB = 22, RWB = 3;
  localparam int XC = 5,   MC = 3,  KC = 8, NC = 1,  RWC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [XA-1:0]  a_x;
  logic [RWA-1:0] a_r;
  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [XB-1:0]  b_x;
  logic [RWB-1:0] b_r;
  logic           c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [XC-1:0]  c_x;
  logic [RWC-1:0] c_r;

  x_mod_m_seq #(.XW(XA), .M(MA), .K(KA)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .X(a_x),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .R(a_r), .busy(a_busy));
  x_mod_m_seq #(.XW(XB), .M(MB), .K(KB)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .X(b_x),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .R(b_r), .busy(b_busy));
  x_mod_m_seq #(.XW(XC), .M(MC), .K(KC)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .X(c_x),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .R(c_r), .busy(c_busy));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [XA-1:0] rand_a();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[XA-1:0];
  endfunction

  // Accept x on instance A and wait for out_valid; no output handshake yet.
  task automatic op_a(input logic [XA-1:0] x, output logic [RWA-1:0] r, output int lat);
    int w;
    w = 0;
    while (!a_in_ready && w < 200) begin @(negedge clk); w++; end
    check("a_in_ready_wait", 64'(a_in_ready), 64'(1));
    a_x = x;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_x = rand_a();
    check("a_busy_after_accept", 64'(a_busy), 64'(1));
    lat = 0;
    while (!a_out_valid && lat < NA + 10) begin
      a_out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    a_out_ready = 1'b0;
    r = a_r;
  endtask

  task automatic hs_a();
    a_out_ready = 1'b1;
    @(negedge clk);
    check("a_hs_out_valid", 64'(a_out_valid), 64'(0));
    check("a_hs_in_ready", 64'(a_in_ready), 64'(1));
    a_out_ready = 1'b0;
  endtask

  task automatic run_a(input string tag, input logic [XA-1:0] x, input logic [RWA-1:0] exp);
    logic [RWA-1:0] r;
    int lat;
    op_a(x, r, lat);
    check(tag, 64'(r), 64'(exp));
    check("a_latency", 64'(lat), 64'(NA));
    hs_a();
  endtask

  task automatic run_b(input logic [XB-1:0] x);
    int w, lat;
    w = 0;
    while (!b_in_ready && w < 100) begin @(negedge clk); w++; end
    b_x = x;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_x = {$urandom, $urandom};
    lat = 0;
    while (!b_out_valid && lat < NB + 10) begin
      b_out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("b_result", 64'(b_r), 64'(x % 64'(MB)));
    check("b_latency", 64'(lat), 64'(NB));
    b_out_ready = 1'b1;
    @(negedge clk);
    check("b_hs_in_ready", 64'(b_in_ready), 64'(1));
    b_out_ready = 1'b0;
  endtask

  task automatic run_c(input logic [XC-1:0] x);
    int w, lat;
    w = 0;
    while (!c_in_ready && w < 100) begin @(negedge clk); w++; end
    c_x = x;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    c_x = 5'($urandom);
    lat = 0;
    while (!c_out_valid && lat < NC + 10) begin
      c_out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("c_result", 64'(c_r), 64'(x % 5'(MC)));
    check("c_latency", 64'(lat), 64'(NC));
    c_out_ready = 1'b1;
    @(negedge clk);
    check("c_hs_in_ready", 64'(c_in_ready), 64'(1));
    c_out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [XA-1:0]  xa;
    logic [RWA-1:0] ra, ref_r;
    int             lat, rises;

    rst = 1'b1;
    a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    a_x = '0; b_x = '0; c_x = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready_low_a", 64'(a_in_ready), 64'(0));
    check("rst_in_ready_low_c", 64'(c_in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(a_in_ready), 64'(1));
    check("post_rst_out_valid", 64'(a_out_valid), 64'(0));
    check("post_rst_busy", 64'(a_busy), 64'(0));
    check("post_rst_r", 64'(a_r), 64'(0));
    check("post_rst_busy_b", 64'(b_busy), 64'(0));
    @(negedge clk);

    run_a("a_x0", '0, 6'd0);
    run_a("a_x52", XA'(52), 6'd52);
    run_a("a_x53", XA'(53), 6'd0);
    run_a("a_x54", XA'(54), 6'd1);
    xa = '1;
    run_a("a_all_ones", xa, 6'd45);
    xa = '0;
    xa[XA-1] = 1'b1;
    run_a("a_top_bit", xa, 6'd23);

    // Back-pressure: DONE must hold R and refuse new operands.
    xa = rand_a();
    ref_r = RWA'(xa % XA'(MA));
    op_a(xa, ra, lat);
    check("bp_result", 64'(ra), 64'(ref_r));
    for (int i = 0; i < 5; i++) begin
      a_x = rand_a();
      a_in_valid = 1'($urandom);
      a_out_ready = 1'b0;
      @(negedge clk);
      check("bp_out_valid", 64'(a_out_valid), 64'(1));
      check("bp_r_stable", 64'(a_r), 64'(ref_r));
      check("bp_in_ready", 64'(a_in_ready), 64'(0));
    end
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_out_valid", 64'(a_out_valid), 64'(0));
    check("bp_hs_no_accept", 64'(a_busy), 64'(0));
    check("bp_hs_in_ready", 64'(a_in_ready), 64'(1));
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;

    // Reset 20 edges into BUSY aborts the operation.
    a_x = rand_a();
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_before", 64'(a_busy), 64'(1));
    rst = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check("abort_in_ready_low", 64'(a_in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(a_in_ready), 64'(1));
    check("abort_out_valid", 64'(a_out_valid), 64'(0));
    check("abort_r", 64'(a_r), 64'(0));
    rises = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_out_valid) rises++;
    end
    check("abort_no_out_valid", 64'(rises), 64'(0));
    a_out_ready = 1'b0;
    run_a("a_x106", XA'(106), 6'd0);

    fork
      begin
        logic [XA-1:0]  x1;
        logic [RWA-1:0] r1;
        int             l1;
        for (int i = 0; i < 300; i++) begin
          x1 = rand_a();
          if (i % 37 == 0) x1 = '1;
          op_a(x1, r1, l1);
          check("a_rand_result", 64'(r1), 64'(x1 % XA'(MA)));
          check("a_rand_latency", 64'(l1), 64'(NA));
          hs_a();
        end
      end
      begin
        logic [XB-1:0] x2;
        for (int i = 0; i < 800; i++) begin
          x2 = {$urandom, $urandom};
          if (i % 50 == 0) x2 = '1;
          run_b(x2);
        end
      end
      begin
        for (int i = 0; i < 2000; i++) run_c(5'($urandom));
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
